// File: rtl/ast_packet_arbiter_pkg.sv
// Shared types and helpers for the packet-granular Avalon-ST arbiter.
package ast_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  // $clog2 that never returns zero, so single-entry fields stay one bit wide
  function automatic int unsigned clog2_min1(input int unsigned n);
    return ($clog2(n) != 0) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ast_packet_arbiter_if.sv
// N-sink / one-source Avalon-ST bundle seen by the arbiter; slave is the arbiter side.
interface ast_packet_arbiter_if
  import ast_arb_pkg::*;
#(
  parameter int unsigned N_PORTS   = 4,
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned EMPTY_W   = clog2_min1(DATA_W / 8),
  parameter int unsigned CHANNEL_W = 10
);

  logic [N_PORTS*DATA_W-1:0]    ast_data_i;
  logic [N_PORTS-1:0]           ast_startofpacket_i;
  logic [N_PORTS-1:0]           ast_endofpacket_i;
  logic [N_PORTS-1:0]           ast_valid_i;
  logic [N_PORTS*EMPTY_W-1:0]   ast_empty_i;
  logic [N_PORTS*CHANNEL_W-1:0] ast_channel_i;
  logic [N_PORTS-1:0]           ast_ready_o;

  logic [DATA_W-1:0]            ast_data_o;
  logic                         ast_startofpacket_o;
  logic                         ast_endofpacket_o;
  logic                         ast_valid_o;
  logic [EMPTY_W-1:0]           ast_empty_o;
  logic [CHANNEL_W-1:0]         ast_channel_o;
  logic                         ast_ready_i;

  modport slave (
    input  ast_data_i, ast_startofpacket_i, ast_endofpacket_i, ast_valid_i,
           ast_empty_i, ast_channel_i, ast_ready_i,
    output ast_ready_o, ast_data_o, ast_startofpacket_o, ast_endofpacket_o,
           ast_valid_o, ast_empty_o, ast_channel_o
  );

  modport master (
    output ast_data_i, ast_startofpacket_i, ast_endofpacket_i, ast_valid_i,
           ast_empty_i, ast_channel_i, ast_ready_i,
    input  ast_ready_o, ast_data_o, ast_startofpacket_o, ast_endofpacket_o,
           ast_valid_o, ast_empty_o, ast_channel_o
  );

endinterface

// File: rtl/ast_packet_arbiter_rr_picker.sv
// Round-robin pick: first set request at or after ptr_i, wrapping upward.
module rr_picker #(
  parameter int unsigned N_PORTS = 4,
  parameter int unsigned IDX_W   = 2
) (
  input  logic [N_PORTS-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic               found_o,
  output logic [IDX_W-1:0]   pick_o
);

  localparam int unsigned SUM_W = IDX_W + 1;

  logic [N_PORTS-1:0] rot_c;
  logic [IDX_W-1:0]   off_c;

  function automatic logic [IDX_W-1:0] wrap_idx(input logic [SUM_W-1:0] v);
    logic [SUM_W-1:0] r;
    r = (v >= SUM_W'(N_PORTS)) ? v - SUM_W'(N_PORTS) : v;
    return r[IDX_W-1:0];
  endfunction

  // rotate so that ptr_i lands on bit 0
  always_comb begin
    rot_c = '0;
    for (int unsigned i = 0; i < N_PORTS; i++) begin
      rot_c[i] = req_i[wrap_idx({1'b0, ptr_i} + SUM_W'(i))];
    end
  end

  always_comb begin
    found_o = 1'b0;
    off_c   = '0;
    for (int i = int'(N_PORTS) - 1; i >= 0; i--) begin
      if (rot_c[i]) begin
        found_o = 1'b1;
        off_c   = IDX_W'(i);
      end
    end
    pick_o = wrap_idx({1'b0, ptr_i} + {1'b0, off_c});
  end

endmodule

// File: rtl/ast_packet_arbiter.sv
// Packet-granular round-robin merge of N Avalon-ST sources into one registered stream.
module ast_packet_arbiter
  import ast_arb_pkg::*;
#(
  parameter int unsigned N_PORTS   = 4,
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned EMPTY_W   = clog2_min1(DATA_W / 8),
  parameter int unsigned CHANNEL_W = 10,
  parameter int unsigned IDX_W     = clog2_min1(N_PORTS)
) (
  input  logic                 clk_i,
  input  logic                 srst_i,
  ast_packet_arbiter_if.slave  bus,
  output logic [IDX_W-1:0]     grant_idx_o
);

  arb_state_t state_q, state_d;

  logic [IDX_W-1:0]     grant_q, grant_d, ptr_q, ptr_d, gidx_q, gidx_d;
  logic                 valid_q, valid_d, sop_q, sop_d, eop_q, eop_d;
  logic [DATA_W-1:0]    data_q, data_d;
  logic [EMPTY_W-1:0]   empty_q, empty_d;
  logic [CHANNEL_W-1:0] channel_q, channel_d;

  logic                 found_c;
  logic [IDX_W-1:0]     pick_c;
  logic                 sel_valid_c, sel_sop_c, sel_eop_c;
  logic [DATA_W-1:0]    sel_data_c;
  logic [EMPTY_W-1:0]   sel_empty_c;
  logic [CHANNEL_W-1:0] sel_channel_c;
  logic                 out_free_c, in_fire_c, last_beat_c;

  rr_picker #(
    .N_PORTS (N_PORTS),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req_i   (bus.ast_valid_i),
    .ptr_i   (ptr_q),
    .found_o (found_c),
    .pick_o  (pick_c)
  );

  // granted-port view of the sink bundle
  always_comb begin
    sel_valid_c   = 1'b0;
    sel_sop_c     = 1'b0;
    sel_eop_c     = 1'b0;
    sel_data_c    = '0;
    sel_empty_c   = '0;
    sel_channel_c = '0;
    for (int unsigned k = 0; k < N_PORTS; k++) begin
      if (grant_q == IDX_W'(k)) begin
        sel_valid_c   = bus.ast_valid_i[k];
        sel_sop_c     = bus.ast_startofpacket_i[k];
        sel_eop_c     = bus.ast_endofpacket_i[k];
        sel_data_c    = bus.ast_data_i[k*DATA_W +: DATA_W];
        sel_empty_c   = bus.ast_empty_i[k*EMPTY_W +: EMPTY_W];
        sel_channel_c = bus.ast_channel_i[k*CHANNEL_W +: CHANNEL_W];
      end
    end
  end

  assign out_free_c  = !valid_q || bus.ast_ready_i;
  assign in_fire_c   = (state_q == BUSY) && out_free_c && sel_valid_c;
  assign last_beat_c = in_fire_c && sel_eop_c;

  always_ff @(posedge clk_i) begin
    if (srst_i) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (found_c) state_d = BUSY;
      BUSY:    if (last_beat_c) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ready is combinational from downstream ready: no skid buffer
  always_comb begin
    bus.ast_ready_o = '0;
    if (state_q == BUSY) bus.ast_ready_o[grant_q] = out_free_c;
  end

  always_comb begin
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    gidx_d    = gidx_q;
    valid_d   = valid_q;
    sop_d     = sop_q;
    eop_d     = eop_q;
    data_d    = data_q;
    empty_d   = empty_q;
    channel_d = channel_q;
    if ((state_q == IDLE) && found_c) grant_d = pick_c;
    if (last_beat_c) begin
      ptr_d = (grant_q == IDX_W'(N_PORTS - 1)) ? '0 : grant_q + IDX_W'(1);
    end
    if (in_fire_c) begin
      valid_d   = 1'b1;
      sop_d     = sel_sop_c;
      eop_d     = sel_eop_c;
      data_d    = sel_data_c;
      empty_d   = sel_empty_c;
      channel_d = sel_channel_c;
      gidx_d    = grant_q;
    end else if (valid_q && bus.ast_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      grant_q   <= '0;
      ptr_q     <= '0;
      gidx_q    <= '0;
      valid_q   <= 1'b0;
      sop_q     <= 1'b0;
      eop_q     <= 1'b0;
      data_q    <= '0;
      empty_q   <= '0;
      channel_q <= '0;
    end else begin
      grant_q   <= grant_d;
      ptr_q     <= ptr_d;
      gidx_q    <= gidx_d;
      valid_q   <= valid_d;
      sop_q     <= sop_d;
      eop_q     <= eop_d;
      data_q    <= data_d;
      empty_q   <= empty_d;
      channel_q <= channel_d;
    end
  end

  assign bus.ast_valid_o         = valid_q;
  assign bus.ast_startofpacket_o = sop_q;
  assign bus.ast_endofpacket_o   = eop_q;
  assign bus.ast_data_o          = data_q;
  assign bus.ast_empty_o         = empty_q;
  assign bus.ast_channel_o       = channel_q;
  assign grant_idx_o             = gidx_q;

endmodule

// File: tb/tb_ast_packet_arbiter.sv
// Directed and scoreboarded stimulus for ast_packet_arbiter (4 ports, 64-bit data).
module tb_ast_packet_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned DW = 64;
  localparam int unsigned EW = 3;
  localparam int unsigned CW = 10;
  localparam int unsigned IW = 2;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          sop;
    logic          eop;
    logic [EW-1:0] empty;
    logic [CW-1:0] ch;
  } beat_t;

  typedef struct {
    beat_t       b;
    int unsigned port;
    int          cyc;
  } rx_t;

  logic          clk  = 1'b0;
  logic          srst = 1'b1;
  logic [IW-1:0] gidx;

  ast_packet_arbiter_if #(.N_PORTS(N), .DATA_W(DW), .EMPTY_W(EW), .CHANNEL_W(CW)) bus ();

  ast_packet_arbiter #(
    .N_PORTS(N), .DATA_W(DW), .EMPTY_W(EW), .CHANNEL_W(CW), .IDX_W(IW)
  ) dut (
    .clk_i       (clk),
    .srst_i      (srst),
    .bus         (bus),
    .grant_idx_o (gidx)
  );

  always #5 clk = ~clk;

  beat_t srcq[N][$];
  beat_t expq[N][$];
  rx_t   rxq[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  beat_t prev_out;
  bit    prev_stall = 1'b0;
  bit    pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    beat_t b;
    for (int k = 0; k < int'(N); k++) begin
      if (srcq[k].size() > 0) begin
        b = srcq[k][0];
        bus.ast_valid_i[k]            = 1'b1;
        bus.ast_startofpacket_i[k]    = b.sop;
        bus.ast_endofpacket_i[k]      = b.eop;
        bus.ast_data_i[k*DW +: DW]    = b.data;
        bus.ast_empty_i[k*EW +: EW]   = b.empty;
        bus.ast_channel_i[k*CW +: CW] = b.ch;
      end else begin
        bus.ast_valid_i[k] = 1'b0;
      end
    end
  endtask

  // one clock: apply inputs at the negedge, settle, record handshakes, wait for next negedge
  task automatic step(input bit rdy);
    beat_t ob;
    bus.ast_ready_i = rdy;
    drive();
    #1;
    ob = {bus.ast_data_o, bus.ast_startofpacket_o, bus.ast_endofpacket_o,
          bus.ast_empty_o, bus.ast_channel_o};
    if (prev_stall) check("stall_hold", 128'({bus.ast_valid_o, ob}), 128'({1'b1, prev_out}));
    if (bus.ast_valid_o && !rdy) check("stall_ready", 128'(bus.ast_ready_o), 128'(0));
    prev_stall = bus.ast_valid_o && !rdy && !srst;
    prev_out   = ob;
    if (!srst) begin
      for (int k = 0; k < int'(N); k++) begin
        if (bus.ast_valid_i[k] && bus.ast_ready_o[k]) void'(srcq[k].pop_front());
      end
      if (bus.ast_valid_o && rdy) rxq.push_back('{b: ob, port: 32'(gidx), cyc: cyc});
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic push_pkt(input int unsigned port, input int len, input logic [DW-1:0] base,
                          input logic [EW-1:0] emp, input logic [CW-1:0] ch);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.data  = base + DW'(i);
      b.sop   = (i == 0);
      b.eop   = (i == len - 1);
      b.empty = (i == len - 1) ? emp : '0;
      b.ch    = ch;
      srcq[port].push_back(b);
      expq[port].push_back(b);
    end
  endtask

  // pct < 0 selects the fixed 1,0,0,1 ready pattern
  task automatic drain(input int pct, input int maxc);
    int n;
    bit busy;
    bit rdy;
    n    = 0;
    busy = 1'b1;
    while (busy && n < maxc) begin
      rdy = (pct < 0) ? pat[n % 4] : (int'($urandom_range(99)) < pct);
      step(rdy);
      n++;
      busy = bus.ast_valid_o;
      for (int k = 0; k < int'(N); k++) if (srcq[k].size() > 0) busy = 1'b1;
    end
    check("drain_done", 128'(busy), 128'(0));
  endtask

  task automatic do_reset();
    srst = 1'b1;
    step(1'b1);
    step(1'b1);
    srst = 1'b0;
  endtask

  task automatic clear_exp();
    for (int k = 0; k < int'(N); k++) expq[k].delete();
    rxq.delete();
  endtask

  initial begin
    int c0;
    int pct;
    int npk;
    int unsigned pk_port;
    bit new_pkt;
    int left;
    int unsigned ord2[5];
    int unsigned ord4a[2];
    int unsigned ord4b[3];
    logic [DW-1:0] base2[5];

    bus.ast_valid_i         = '0;
    bus.ast_startofpacket_i = '0;
    bus.ast_endofpacket_i   = '0;
    bus.ast_data_i          = '0;
    bus.ast_empty_i         = '0;
    bus.ast_channel_i       = '0;
    bus.ast_ready_i         = 1'b1;

    // reset state
    do_reset();
    check("rst_valid", 128'(bus.ast_valid_o), 128'(0));
    check("rst_ready", 128'(bus.ast_ready_o), 128'(0));
    check("rst_payload", 128'({bus.ast_data_o, bus.ast_startofpacket_o, bus.ast_endofpacket_o,
                               bus.ast_empty_o, bus.ast_channel_o}), 128'(0));
    check("rst_gidx", 128'(gidx), 128'(0));

    // single 3-beat packet on port 2
    clear_exp();
    push_pkt(2, 3, 64'hA, 3'd4, 10'h2A5);
    c0 = cyc;
    drain(100, 50);
    check("t1_count", 128'(rxq.size()), 128'(3));
    for (int i = 0; i < 3; i++) begin
      if (i < rxq.size()) begin
        check("t1_data", 128'(rxq[i].b.data), 128'(64'hA + 64'(i)));
        check("t1_sop_eop", 128'({rxq[i].b.sop, rxq[i].b.eop}), 128'({i == 0, i == 2}));
        check("t1_grant", 128'(rxq[i].port), 128'(2));
        check("t1_cycle", 128'(rxq[i].cyc - c0), 128'(2 + i));
      end
    end
    check("t1_empty_ch", 128'({rxq[2].b.empty, rxq[2].b.ch}), 128'({3'd4, 10'h2A5}));

    // all ports busy: order 0,1,2,3,0 with one idle cycle between packets
    do_reset();
    clear_exp();
    ord2  = '{0, 1, 2, 3, 0};
    base2 = '{64'h100, 64'h110, 64'h120, 64'h130, 64'h140};
    for (int p = 0; p < 5; p++) push_pkt(ord2[p], 2, base2[p], 3'd0, 10'(p));
    c0 = cyc;
    drain(100, 80);
    check("t2_count", 128'(rxq.size()), 128'(10));
    for (int i = 0; i < 10; i++) begin
      if (i < rxq.size()) begin
        check("t2_grant", 128'(rxq[i].port), 128'(ord2[i/2]));
        check("t2_data", 128'(rxq[i].b.data), 128'(base2[i/2] + 64'(i % 2)));
        check("t2_cycle", 128'(rxq[i].cyc - c0), 128'(2 + 3*(i/2) + (i % 2)));
      end
    end

    // single-beat packets on 0 and 3 with pointer at 1
    clear_exp();
    push_pkt(0, 1, 64'h200, 3'd5, 10'h055);
    push_pkt(3, 1, 64'h300, 3'd2, 10'h3AA);
    ord4a = '{3, 0};
    c0 = cyc;
    drain(100, 40);
    check("t4_count", 128'(rxq.size()), 128'(2));
    if (rxq.size() == 2) begin
      check("t4_first", 128'(rxq[0].port), 128'(ord4a[0]));
      check("t4_second", 128'(rxq[1].port), 128'(ord4a[1]));
      check("t4_beat3", 128'(rxq[0].b), 128'({64'h300, 1'b1, 1'b1, 3'd2, 10'h3AA}));
      check("t4_beat0", 128'(rxq[1].b), 128'({64'h200, 1'b1, 1'b1, 3'd5, 10'h055}));
      check("t4_cycles", 128'({32'(rxq[0].cyc - c0), 32'(rxq[1].cyc - c0)}), 128'({32'd2, 32'd4}));
    end
    // pointer left at 1: ports 0,1,2 competing give 1,2,0
    clear_exp();
    push_pkt(0, 1, 64'h400, 3'd0, 10'd0);
    push_pkt(1, 1, 64'h410, 3'd0, 10'd1);
    push_pkt(2, 1, 64'h420, 3'd0, 10'd2);
    ord4b = '{1, 2, 0};
    drain(100, 40);
    check("t4_ptr_count", 128'(rxq.size()), 128'(3));
    for (int i = 0; i < 3; i++) if (i < rxq.size()) check("t4_ptr_order", 128'(rxq[i].port), 128'(ord4b[i]));

    // backpressure with ready 1,0,0,1 on a 4-beat packet from port 1
    clear_exp();
    push_pkt(1, 4, 64'h500, 3'd7, 10'h111);
    drain(-1, 60);
    check("t3_count", 128'(rxq.size()), 128'(4));
    for (int i = 0; i < 4; i++) begin
      if (i < rxq.size()) begin
        check("t3_data", 128'(rxq[i].b.data), 128'(64'h500 + 64'(i)));
        check("t3_grant", 128'(rxq[i].port), 128'(1));
      end
    end

    // reset after two beats of a 5-beat packet on port 0
    clear_exp();
    push_pkt(0, 5, 64'h600, 3'd0, 10'h0);
    for (int n = 0; n < 10 && srcq[0].size() > 3; n++) step(1'b1);
    check("t5_two_beats", 128'(srcq[0].size()), 128'(3));
    srst = 1'b1;
    step(1'b1);
    srst = 1'b0;
    check("t5_valid", 128'(bus.ast_valid_o), 128'(0));
    check("t5_ready", 128'(bus.ast_ready_o), 128'(0));
    srcq[0].delete();
    clear_exp();
    push_pkt(1, 2, 64'h700, 3'd1, 10'h0F0);
    drain(100, 40);
    check("t5_count", 128'(rxq.size()), 128'(2));
    for (int i = 0; i < 2; i++) begin
      if (i < rxq.size()) begin
        check("t5_grant", 128'(rxq[i].port), 128'(1));
        check("t5_data", 128'(rxq[i].b.data), 128'(64'h700 + 64'(i)));
      end
    end

    // random packets under 100/50/10 percent downstream ready
    for (int ph = 0; ph < 3; ph++) begin
      pct = (ph == 0) ? 100 : (ph == 1) ? 50 : 10;
      npk = (ph == 0) ? 80 : (ph == 1) ? 50 : 25;
      clear_exp();
      for (int p = 0; p < npk; p++) begin
        push_pkt($urandom_range(N - 1), int'($urandom_range(20, 1)), {$urandom, $urandom},
                 EW'($urandom), CW'($urandom));
      end
      drain(pct, 20000);
      new_pkt = 1'b1;
      pk_port = 0;
      for (int i = 0; i < rxq.size(); i++) begin
        if (new_pkt) begin
          pk_port = rxq[i].port;
          new_pkt = 1'b0;
        end else begin
          check("rnd_no_interleave", 128'(rxq[i].port), 128'(pk_port));
        end
        check("rnd_exp_avail", 128'(expq[pk_port].size() > 0), 128'(1));
        if (expq[pk_port].size() > 0) check("rnd_beat", 128'(rxq[i].b), 128'(expq[pk_port].pop_front()));
        if (rxq[i].b.eop) new_pkt = 1'b1;
      end
      left = 0;
      for (int k = 0; k < int'(N); k++) left += expq[k].size();
      check("rnd_leftover", 128'(left), 128'(0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
